// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - training sequencer and accuracy scorer for a fixed-point perceptron
module perceptron_trainer #(
    parameter int                            input_units  = 2,
    parameter logic [(1<<input_units)-1:0]   target_table = 4'b1000,
    parameter int                            max_epochs   = 10,
    parameter int                            pred_latency = 1,
    parameter int                            sfp_width    = 16,
    parameter int                            sfp_frac     = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [sfp_width-1:0]                       lr_in,
    input  logic [sfp_width-1:0]                       prediction,
    output logic [input_units-1:0][sfp_width-1:0]      values,
    output logic                                       training,
    output logic [sfp_width-1:0]                       learning_rate,
    output logic [sfp_width-1:0]                       expected,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       converged,
    output logic [$clog2(max_epochs+1)-1:0]            epoch,
    output logic [$clog2((1<<input_units)+1)-1:0]      correct
);

    localparam int num_samples = 1 << input_units;
    localparam int epoch_w     = $clog2(max_epochs + 1);
    localparam int cnt_w       = $clog2(num_samples + 1);

    localparam logic [sfp_width-1:0]   one         = {{(sfp_width-1){1'b0}}, 1'b1} << sfp_frac;
    localparam logic [input_units-1:0] last_sample = '1;
    localparam logic [7:0]             hold_last   = 8'(pred_latency);
    localparam logic [epoch_w-1:0]     last_epoch  = epoch_w'(max_epochs - 1);
    localparam logic [cnt_w-1:0]       full_count  = cnt_w'(num_samples);

    typedef enum logic [2:0] {IDLE, TRAIN, EVAL, CHECK, DONE} state_t;

    state_t                 state;
    logic [input_units-1:0] sample;
    logic [7:0]             hold;
    logic [cnt_w-1:0]       run_count;

    function automatic logic [input_units-1:0][sfp_width-1:0] sample_values(input logic [input_units-1:0] k);
        logic [input_units-1:0][sfp_width-1:0] v;
        for (int j = 0; j < input_units; j++) begin
            v[j] = k[j] ? one : '0;
        end
        return v;
    endfunction

    function automatic logic [sfp_width-1:0] sample_target(input logic [input_units-1:0] k);
        return target_table[k] ? one : '0;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            sample        <= '0;
            hold          <= '0;
            run_count     <= '0;
            values        <= '0;
            expected      <= '0;
            training      <= 1'b0;
            learning_rate <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            converged     <= 1'b0;
            epoch         <= '0;
            correct       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        learning_rate <= lr_in;
                        epoch         <= '0;
                        converged     <= 1'b0;
                        sample        <= '0;
                        values        <= sample_values('0);
                        expected      <= sample_target('0);
                        training      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        state         <= TRAIN;
                    end
                end
                TRAIN: begin
                    if (sample == last_sample) begin
                        sample   <= '0;
                        hold     <= '0;
                        values   <= sample_values('0);
                        expected <= sample_target('0);
                        training <= 1'b0;
                        state    <= EVAL;
                    end else begin
                        sample   <= sample + 1'b1;
                        values   <= sample_values(sample + 1'b1);
                        expected <= sample_target(sample + 1'b1);
                    end
                end
                EVAL: begin
                    // Score only on the last edge of the hold, once the perceptron output has settled.
                    if (hold == hold_last) begin
                        hold <= '0;
                        if (prediction == expected) begin
                            run_count <= run_count + 1'b1;
                        end
                        if (sample == last_sample) begin
                            values   <= '0;
                            expected <= '0;
                            state    <= CHECK;
                        end else begin
                            sample   <= sample + 1'b1;
                            values   <= sample_values(sample + 1'b1);
                            expected <= sample_target(sample + 1'b1);
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                CHECK: begin
                    correct   <= run_count;
                    run_count <= '0;
                    if (run_count == full_count || epoch == last_epoch) begin
                        converged <= (run_count == full_count);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        epoch    <= epoch + 1'b1;
                        sample   <= '0;
                        values   <= sample_values('0);
                        expected <= sample_target('0);
                        training <= 1'b1;
                        state    <= TRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - randomized bench for perceptron_trainer against a cycle-schedule model
module tb_perceptron_trainer;

    localparam logic [15:0] ONE       = 16'h0100;
    localparam int          EPOCH_LEN = 13;
    localparam int          MAX_EP    = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      lr_in = '0;
    logic [15:0]      prediction = '0;
    logic [1:0][15:0] values;
    logic             training;
    logic [15:0]      learning_rate;
    logic [15:0]      expected;
    logic             busy;
    logic             done;
    logic             converged;
    logic [3:0]       epoch;
    logic [2:0]       correct;

    int         checks = 0;
    int         errors = 0;
    int         prev_correct = 0;
    int         mock_fix = 0;
    logic [3:0] mock_mask = '0;
    bit         mock_stuck = 1'b0;

    perceptron_trainer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .lr_in         (lr_in),
        .prediction    (prediction),
        .values        (values),
        .training      (training),
        .learning_rate (learning_rate),
        .expected      (expected),
        .busy          (busy),
        .done          (done),
        .converged     (converged),
        .epoch         (epoch),
        .correct       (correct)
    );

    always #5 clk = ~clk;

    // Perceptron stand-in with one cycle of latency: answers wrongly on masked samples until epoch mock_fix.
    always @(posedge clk) begin
        logic [1:0] k;
        k = {values[1] != 16'd0, values[0] != 16'd0};
        if (mock_stuck)
            prediction <= '0;
        else if (int'(epoch) < mock_fix && mock_mask[k])
            prediction <= expected ^ 16'h0001;
        else
            prediction <= expected;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs_vec();
        return {5'b0, busy, done, converged, training, values[1], values[0], expected, epoch, correct};
    endfunction

    function automatic int epoch_correct(input int e, input int fix, input logic [3:0] mask);
        return (e < fix) ? 4 - $countones(mask) : 4;
    endfunction

    // Expected outputs after edge S+t of a run lasting n epochs, derived from the epoch schedule.
    function automatic logic [63:0] model_vec(input int t, input int n, input int fix,
                                              input logic [3:0] mask, input int prev_c);
        logic [3:0]  tgt = 4'b1000;
        int          e = t / EPOCH_LEN;
        int          r = t % EPOCH_LEN;
        int          k = -1;
        logic        b, d, cv, tr;
        logic [15:0] v1, v0, ex;
        logic [3:0]  ep;
        logic [2:0]  c;
        if (t == n * EPOCH_LEN) begin
            b  = 1'b0;
            d  = 1'b1;
            tr = 1'b0;
            ep = 4'(n - 1);
            c  = 3'(epoch_correct(n - 1, fix, mask));
            cv = (c == 3'd4);
        end else begin
            b  = 1'b1;
            d  = 1'b0;
            cv = 1'b0;
            ep = 4'(e);
            c  = 3'((e == 0) ? prev_c : epoch_correct(e - 1, fix, mask));
            tr = (r < 4);
            if (r < 4)       k = r;
            else if (r < 12) k = (r - 4) / 2;
        end
        v0 = (k >= 0 && (k & 1) != 0) ? ONE : 16'd0;
        v1 = (k >= 0 && (k & 2) != 0) ? ONE : 16'd0;
        ex = (k >= 0 && tgt[k[1:0]]) ? ONE : 16'd0;
        return {5'b0, b, d, cv, tr, v1, v0, ex, ep, c};
    endfunction

    task automatic do_run(input logic [15:0] lr, input int fix, input logic [3:0] mask,
                          input bit stuck, input int poke);
        int n = (fix < MAX_EP) ? fix + 1 : MAX_EP;
        @(negedge clk);
        mock_fix   = fix;
        mock_mask  = mask;
        mock_stuck = stuck;
        lr_in      = lr;
        start      = 1'b1;
        for (int t = 0; t <= n * EPOCH_LEN; t++) begin
            @(negedge clk);
            check_eq($sformatf("seq t=%0d fix=%0d", t, fix), obs_vec(),
                     model_vec(t, n, fix, mask, prev_correct));
            start = (t == poke);
            lr_in = 16'($urandom);
        end
        start = 1'b0;
        check_eq("learning_rate", 64'(learning_rate), 64'(lr));
        prev_correct = epoch_correct(n - 1, fix, mask);
    endtask

    task automatic reset_mid_train();
        @(negedge clk);
        mock_fix   = 0;
        mock_stuck = 1'b0;
        lr_in      = 16'h0123;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre-reset busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1 check_eq("async reset outputs", obs_vec(), 64'd0);
        check_eq("async reset lr", 64'(learning_rate), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle after reset", obs_vec(), 64'd0);
        prev_correct = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("reset outputs", obs_vec(), 64'd0);
        check_eq("reset lr", 64'(learning_rate), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle without start", obs_vec(), 64'd0);

        do_run(ONE, 0, 4'b0001, 1'b0, -1);
        do_run(16'h0040, 1000, 4'b1000, 1'b1, 2 * EPOCH_LEN + 4);
        reset_mid_train();
        do_run(ONE, 0, 4'b0110, 1'b0, 5);

        for (int i = 0; i < 6; i++) begin
            do_run(16'($urandom), int'($urandom_range(0, 12)), 4'($urandom_range(1, 15)),
                   1'b0, int'($urandom_range(3, 10)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
